spike_count_decoder: RTL and testbench

Output-side reader for a layer of integrate-and-fire neurons. Counts spikes per neuron over a fixed observation window, then scans the counts sequentially to select the winning neuron (argmax), presenting class index and spike count on a valid/ready output. Sits directly after the IF layer's spike output bus; it is the classification end of the spiking network.

---
 rtl/spike_count_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_spike_count_decoder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_count_decoder.sv
// spike_count_decoder
//
// Classification end of a spiking network. After a start request it counts
// spikes on every neuron line for a fixed window of WINDOW cycles, then walks
// the per-neuron counts one per cycle to find the winner (argmax, ties go to
// the lowest index) and holds class index / spike count on a valid/ready
// output until the consumer accepts it.
//
// Optional feature: define SPIKE_DECODER_TIE_FLAG_EN to add the 'tie' output.
// It flags that another neuron reached the same non-zero winning count.
//
// Flow: IDLE -> COUNT (WINDOW cycles) -> SCAN (NUM_INPUTS cycles) -> HOLD.
// The result registers keep their last values after acceptance, so the last
// classification remains readable while the block is idle.

module spike_count_decoder #(
  parameter int NUM_INPUTS  = 4,
  parameter int WINDOW      = 100,
  parameter int COUNT_WIDTH = 16,
  parameter int CLASS_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_INPUTS-1:0]  spike_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [CLASS_WIDTH-1:0] class_out,
  output logic [COUNT_WIDTH-1:0] max_count,
  output logic                   no_spike
`ifdef SPIKE_DECODER_TIE_FLAG_EN
  ,
  output logic                   tie
`endif
);

  // Window counter only needs to reach WINDOW-1; keep at least one bit.
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SCAN  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                   state_q, state_d;

  // Control strobes decoded from the state machine.
  logic                     clr_en;
  logic                     cnt_en;
  logic                     scan_en;
  logic                     load_en;
  logic                     win_last;
  logic                     scan_last;

  logic [WIN_W-1:0]         win_q;
  logic [COUNT_WIDTH-1:0]   cnt_q [NUM_INPUTS];

  // Running argmax state while scanning.
  logic [CLASS_WIDTH-1:0]   scan_idx_q;
  logic [COUNT_WIDTH-1:0]   cur_cnt;
  logic [COUNT_WIDTH-1:0]   best_cnt_q, best_cnt_d;
  logic [CLASS_WIDTH-1:0]   best_idx_q, best_idx_d;

  // Presented result.
  logic [CLASS_WIDTH-1:0]   class_q;
  logic [COUNT_WIDTH-1:0]   max_q;
  logic                     no_spike_q;

`ifdef SPIKE_DECODER_TIE_FLAG_EN
  logic                     tie_scan_q, tie_scan_d;
  logic                     tie_q;
`endif

  // Counters stick at all-ones instead of wrapping so a hot neuron never
  // appears to have fired fewer times than a quieter one.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] c,
    input logic                   hit
  );
    if (hit && (c != {COUNT_WIDTH{1'b1}})) begin
      return c + COUNT_WIDTH'(1);
    end
    return c;
  endfunction

  assign win_last  = (win_q == WIN_W'(WINDOW - 1));
  assign scan_last = (scan_idx_q == CLASS_WIDTH'(NUM_INPUTS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    state_d      = state_q;
    clr_en       = 1'b0;
    cnt_en       = 1'b0;
    scan_en      = 1'b0;
    load_en      = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          clr_en  = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        cnt_en = 1'b1;
        if (win_last) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        scan_en = 1'b1;
        if (scan_last) begin
          load_en = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Window length counter: counts COUNT cycles from zero.
  always_ff @(posedge clk) begin
    if (rst || clr_en) begin
      win_q <= '0;
    end else if (cnt_en) begin
      win_q <= win_q + WIN_W'(1);
    end
  end

  // Per-neuron saturating spike counters; spikes only land during COUNT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rst || clr_en) begin
        cnt_q[i] <= '0;
      end else if (cnt_en) begin
        cnt_q[i] <= sat_inc(cnt_q[i], spike_in[i]);
      end
    end
  end

  // One argmax step: select the count under the scan pointer and compare
  // strictly against the best so far, so earlier indices win ties.
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (scan_idx_q == CLASS_WIDTH'(i)) begin
        cur_cnt = cnt_q[i];
      end
    end
    best_cnt_d = best_cnt_q;
    best_idx_d = best_idx_q;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
    tie_scan_d = tie_scan_q;
`endif
    if (cur_cnt > best_cnt_q) begin
      best_cnt_d = cur_cnt;
      best_idx_d = scan_idx_q;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      tie_scan_d = 1'b0;
`endif
    end
`ifdef SPIKE_DECODER_TIE_FLAG_EN
    else if ((cur_cnt == best_cnt_q) && (best_cnt_q != '0)) begin
      tie_scan_d = 1'b1;
    end
`endif
  end

  // Scan pointer and running best; cleared on a new start so the search
  // begins from index 0 with count 0.
  always_ff @(posedge clk) begin
    if (rst || clr_en) begin
      scan_idx_q <= '0;
      best_cnt_q <= '0;
      best_idx_q <= '0;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      tie_scan_q <= 1'b0;
`endif
    end else if (scan_en) begin
      best_cnt_q <= best_cnt_d;
      best_idx_q <= best_idx_d;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      tie_scan_q <= tie_scan_d;
`endif
      if (!scan_last) begin
        scan_idx_q <= scan_idx_q + CLASS_WIDTH'(1);
      end
    end
  end

  // Result registers: loaded with the final comparison as HOLD is entered,
  // then left untouched until the next completed scan or a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      class_q    <= '0;
      max_q      <= '0;
      no_spike_q <= 1'b0;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      tie_q      <= 1'b0;
`endif
    end else if (load_en) begin
      class_q    <= best_idx_d;
      max_q      <= best_cnt_d;
      no_spike_q <= (best_cnt_d == '0);
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      tie_q      <= tie_scan_d;
`endif
    end
  end

  assign class_out = class_q;
  assign max_count = max_q;
  assign no_spike  = no_spike_q;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
  assign tie       = tie_q;
`endif

endmodule

// File: tb/tb_spike_count_decoder.sv
// Testbench for spike_count_decoder.
// Main instance: 4 neurons, 10-cycle window, 16-bit counters.
// Second instance: 4 neurons, 20-cycle window, 3-bit counters (saturation).
// The reference model works on whole windows: total spikes per neuron,
// clipped to the counter maximum, then argmax with lowest-index tie-break.

module tb_spike_count_decoder;

  localparam int NI   = 4;
  localparam int CL   = 2;
  localparam int WM   = 10;
  localparam int CWM  = 16;
  localparam int WS   = 20;
  localparam int CWS  = 3;
  localparam int MAXM = (1 << CWM) - 1;
  localparam int MAXS = (1 << CWS) - 1;

  logic clk = 1'b0;
  logic rst;

  logic           m_start, m_ready, m_busy, m_valid, m_nospk;
  logic [NI-1:0]  m_spike;
  logic [CL-1:0]  m_cls;
  logic [CWM-1:0] m_max;

  logic           s_start, s_ready, s_busy, s_valid, s_nospk;
  logic [NI-1:0]  s_spike;
  logic [CL-1:0]  s_cls;
  logic [CWS-1:0] s_max;

`ifdef SPIKE_DECODER_TIE_FLAG_EN
  logic m_tie, s_tie;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [NI-1:0] pat [WS];

  always #5 clk = ~clk;

  spike_count_decoder #(
    .NUM_INPUTS(NI), .WINDOW(WM), .COUNT_WIDTH(CWM), .CLASS_WIDTH(CL)
  ) dut (
    .clk(clk), .rst(rst), .start(m_start), .spike_in(m_spike),
    .busy(m_busy), .result_valid(m_valid), .result_ready(m_ready),
    .class_out(m_cls), .max_count(m_max), .no_spike(m_nospk)
`ifdef SPIKE_DECODER_TIE_FLAG_EN
    , .tie(m_tie)
`endif
  );

  spike_count_decoder #(
    .NUM_INPUTS(NI), .WINDOW(WS), .COUNT_WIDTH(CWS), .CLASS_WIDTH(CL)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .spike_in(s_spike),
    .busy(s_busy), .result_valid(s_valid), .result_ready(s_ready),
    .class_out(s_cls), .max_count(s_max), .no_spike(s_nospk)
`ifdef SPIKE_DECODER_TIE_FLAG_EN
    , .tie(s_tie)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one window on the main instance with pattern pat[0..WM-1], then
  // stall acceptance for hold_cycles cycles while poking start and spikes.
  task automatic run_main(input string name, input int hold_cycles);
    int cnt [NI];
    int exp_max, exp_cls, nmax, lat;
    logic exp_tie;
    logic [CL-1:0]  cls_seen;
    logic [CWM-1:0] max_seen;
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0;
      for (int k = 0; k < WM; k++) cnt[i] += int'(pat[k][i]);
      if (cnt[i] > MAXM) cnt[i] = MAXM;
    end
    exp_max = 0;
    exp_cls = 0;
    for (int i = 0; i < NI; i++) begin
      if (cnt[i] > exp_max) begin
        exp_max = cnt[i];
        exp_cls = i;
      end
    end
    nmax = 0;
    for (int i = 0; i < NI; i++) if (cnt[i] == exp_max) nmax++;
    exp_tie = (exp_max > 0) && (nmax > 1);

    m_start = 1'b1;
    step();
    m_start = 1'b0;
    n_checks++;
    if (m_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, m_busy);
    end
    for (int k = 0; k < WM; k++) begin
      m_spike = pat[k];
      m_ready = 1'($urandom);
      step();
      n_checks++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s valid_early: got %b expected 0 at window cycle %0d", name, m_valid, k);
      end
    end
    // Spikes from here on fall outside COUNT and must not be counted.
    m_spike = 4'hF;
    m_ready = 1'b0;
    lat = 0;
    while (m_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    // valid should first be seen WM+NI edges after the start edge.
    n_checks++;
    if (WM + lat != WM + NI) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, WM + lat, WM + NI);
    end
    n_checks++;
    if (m_cls !== CL'(exp_cls)) begin
      n_fail++;
      $display("FAIL %s class_out: got %0d expected %0d", name, m_cls, exp_cls);
    end
    n_checks++;
    if (m_max !== CWM'(exp_max)) begin
      n_fail++;
      $display("FAIL %s max_count: got %0d expected %0d", name, m_max, exp_max);
    end
    n_checks++;
    if (m_nospk !== (exp_max == 0)) begin
      n_fail++;
      $display("FAIL %s no_spike: got %b expected %b", name, m_nospk, exp_max == 0);
    end
`ifdef SPIKE_DECODER_TIE_FLAG_EN
    n_checks++;
    if (m_tie !== exp_tie) begin
      n_fail++;
      $display("FAIL %s tie: got %b expected %b", name, m_tie, exp_tie);
    end
`endif
    cls_seen = CL'(exp_cls);
    max_seen = CWM'(exp_max);
    for (int h = 0; h < hold_cycles; h++) begin
      m_start = 1'($urandom);
      m_spike = NI'($urandom);
      step();
      n_checks++;
      if (m_valid !== 1'b1 || m_busy !== 1'b1 || m_cls !== cls_seen || m_max !== max_seen) begin
        n_fail++;
        $display("FAIL %s hold_stable: valid=%b busy=%b class=%0d max=%0d expected 1 1 %0d %0d",
                 name, m_valid, m_busy, m_cls, m_max, cls_seen, max_seen);
      end
    end
    m_start = 1'b0;
    m_spike = '0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: valid=%b busy=%b expected 0 0", name, m_valid, m_busy);
    end
    n_checks++;
    if (m_cls !== cls_seen || m_max !== max_seen) begin
      n_fail++;
      $display("FAIL %s retain_idle: class=%0d max=%0d expected %0d %0d",
               name, m_cls, m_max, cls_seen, max_seen);
    end
  endtask

  task automatic fill_random();
    int dens [NI];
    for (int i = 0; i < NI; i++) dens[i] = $urandom_range(0, 100);
    for (int k = 0; k < WS; k++)
      for (int i = 0; i < NI; i++)
        pat[k][i] = ($urandom_range(0, 99) < dens[i]);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    m_start = 1'b1;
    s_start = 1'b1;
    m_spike = '1;
    s_spike = '1;
    m_ready = 1'b0;
    s_ready = 1'b0;
    step();
    step();
    rst     = 1'b0;
    m_start = 1'b0;
    s_start = 1'b0;
    n_checks++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_cls !== '0 || m_max !== '0 || m_nospk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_main: busy=%b valid=%b class=%0d max=%0d no_spike=%b expected all 0",
               m_busy, m_valid, m_cls, m_max, m_nospk);
    end
    n_checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_cls !== '0 || s_max !== '0 || s_nospk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sat: busy=%b valid=%b class=%0d max=%0d no_spike=%b expected all 0",
               s_busy, s_valid, s_cls, s_max, s_nospk);
    end
`ifdef SPIKE_DECODER_TIE_FLAG_EN
    n_checks++;
    if (m_tie !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tie: got %b expected 0", m_tie);
    end
`endif
  endtask

  // Spikes while idle are ignored; a following silent window reads zero.
  task automatic test_idle_spikes();
    for (int k = 0; k < 6; k++) begin
      m_spike = NI'($urandom) | 4'h1;
      step();
      n_checks++;
      if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_spikes: busy=%b valid=%b expected 0 0", m_busy, m_valid);
      end
    end
    for (int k = 0; k < WS; k++) pat[k] = '0;
    run_main("no_spike", 0);
  endtask

  task automatic test_directed();
    for (int k = 0; k < WS; k++) pat[k] = 4'b0100 | ((k % 2 == 0) ? 4'b1011 : 4'b0000);
    run_main("directed_n2", 2);
  endtask

  task automatic test_tie();
    for (int k = 0; k < WS; k++) begin
      pat[k] = '0;
      if (k < 5) pat[k] = pat[k] | 4'b1010;
      if (k < 3) pat[k] = pat[k] | 4'b0001;
    end
    run_main("tie_1_3", 1);
  endtask

  task automatic test_hold_stall();
    fill_random();
    pat[0] = 4'b0001;
    run_main("hold_stall", 8);
    // A start pulse seen during HOLD must not have queued a new window.
    step();
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: busy=%b expected 0", m_busy);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      fill_random();
      run_main("random", $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_main("back_to_back", 0);
    end
  endtask

  task automatic test_reset_mid_count();
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    m_spike = '1;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_cls !== '0 || m_max !== '0 || m_nospk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_count: busy=%b valid=%b class=%0d max=%0d no_spike=%b expected all 0",
               m_busy, m_valid, m_cls, m_max, m_nospk);
    end
    step();
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stays_idle: busy=%b expected 0", m_busy);
    end
    m_spike = '0;
    for (int k = 0; k < WS; k++) pat[k] = (k < 7) ? 4'b1000 : 4'b0010;
    run_main("after_reset", 0);
  endtask

  task automatic test_saturation();
    int cnt [NI];
    int exp_max, exp_cls, nmax, lat;
    logic exp_tie;
    fill_random();
    for (int k = 0; k < WS; k++) pat[k][0] = 1'b1;
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0;
      for (int k = 0; k < WS; k++) cnt[i] += int'(pat[k][i]);
      if (cnt[i] > MAXS) cnt[i] = MAXS;
    end
    exp_max = 0;
    exp_cls = 0;
    for (int i = 0; i < NI; i++) begin
      if (cnt[i] > exp_max) begin
        exp_max = cnt[i];
        exp_cls = i;
      end
    end
    nmax = 0;
    for (int i = 0; i < NI; i++) if (cnt[i] == exp_max) nmax++;
    exp_tie = (exp_max > 0) && (nmax > 1);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int k = 0; k < WS; k++) begin
      s_spike = pat[k];
      step();
    end
    s_spike = '0;
    lat = 0;
    while (s_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat != NI) begin
      n_fail++;
      $display("FAIL sat_latency: got %0d edges expected %0d", WS + lat, WS + NI);
    end
    n_checks++;
    if (s_max !== CWS'(exp_max) || s_cls !== CL'(exp_cls) || s_nospk !== 1'b0) begin
      n_fail++;
      $display("FAIL saturation: max=%0d class=%0d no_spike=%b expected %0d %0d 0",
               s_max, s_cls, s_nospk, exp_max, exp_cls);
    end
`ifdef SPIKE_DECODER_TIE_FLAG_EN
    n_checks++;
    if (s_tie !== exp_tie) begin
      n_fail++;
      $display("FAIL sat_tie: got %b expected %b", s_tie, exp_tie);
    end
`endif
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    n_checks++;
    if (s_valid !== 1'b0 || s_max !== CWS'(MAXS)) begin
      n_fail++;
      $display("FAIL sat_accept: valid=%b max=%0d expected 0 %0d", s_valid, s_max, MAXS);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_spikes();
    test_directed();
    test_tie();
    test_hold_stall();
    test_random();
    test_back_to_back();
    test_directed();
    test_reset_mid_count();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
